hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline's decode-stage hazard detector. It tracks per-register pending writes with countdown counters rather than comparing only against the next one or two stage destinations. It stalls IF/ID for RAW and WAW hazards, with configurable load and multiply latencies, and handles taken-branch flushes. It sits in the ID stage and drives PC write enable, IF/ID write enable, the control-bubble select and the IF/ID flush.

---
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register countdown counters track pending
// writes so RAW/WAW consumers stall for exactly the producer's remaining latency.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_mul,
  input  logic              branch_taken,
  input  logic              perf_clr,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              control_dst,
  output logic              if_id_flush,
  output logic              busy,
  output logic [PERF_W-1:0] stall_count
);

  localparam int NREG    = 2 ** REG_AW;
  localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;

  generate
    if (MAX_LAT > (2 ** CNT_W) - 1) begin : g_cnt_too_narrow
      $error("hazard_scoreboard: CNT_W=%0d cannot hold latency %0d", CNT_W, MAX_LAT);
    end
  endgenerate

  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] lat;
  logic             rs_hit;
  logic             rt_hit;
  logic             raw;
  logic             waw;
  logic             stall;
  logic             issue;

  // Multiply wins over load when both flags are set.
  always_comb begin
    lat = '0;
    if (id_mul)
      lat = CNT_W'(MUL_LAT);
    else if (id_memread)
      lat = CNT_W'(LOAD_LAT);
  end

  always_comb begin
    rs_hit = id_rs_used && (id_rs != '0) && (cnt[id_rs] != '0);
    rt_hit = id_rt_used && (id_rt != '0) && (cnt[id_rt] != '0);
    raw    = id_valid && (rs_hit || rt_hit);
    waw    = id_valid && id_regwrite && (id_dst != '0) && (cnt[id_dst] > lat);
    stall  = (raw || waw) && !branch_taken;
    issue  = id_valid && !stall && !branch_taken && id_regwrite && (id_dst != '0);
  end

  always_comb begin
    pc_write    = !stall;
    if_id_write = !stall;
    control_dst = !stall && !branch_taken;
    if_id_flush = branch_taken;
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NREG; r++)
      if (cnt[r] != '0)
        busy = 1'b1;
  end

  // Entry 0 is kept at zero so register zero never appears pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)
          cnt[r] <= '0;
        else if (issue && (id_dst == REG_AW'(r)))
          cnt[r] <= lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (perf_clr)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors push expected outputs,
// a negedge monitor pops and compares. A narrow-counter twin checks saturation.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_rs_used = 1'b0;
  logic       id_rt_used = 1'b0;
  logic [4:0] id_dst = '0;
  logic       id_regwrite = 1'b0;
  logic       id_memread = 1'b0;
  logic       id_mul = 1'b0;
  logic       branch_taken = 1'b0;
  logic       perf_clr = 1'b0;

  logic        pc_write, if_id_write, control_dst, if_id_flush, busy;
  logic [15:0] stall_count;
  logic        sat_pc_write, sat_if_id_write, sat_control_dst, sat_if_id_flush, sat_busy;
  logic [3:0]  sat_stall_count;

  typedef struct {
    string       name;
    logic        pcWrite;
    logic        controlDst;
    logic        flush;
    logic        busy;
    logic [15:0] stallCount;
    logic [3:0]  satCount;
  } expect_t;

  expect_t     expQ[$];
  int          vectorsApplied = 0;
  int          miscompares = 0;
  logic [15:0] tally = '0;
  logic [3:0]  satTally = '0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_mul(id_mul),
    .branch_taken(branch_taken), .perf_clr(perf_clr), .pc_write(pc_write),
    .if_id_write(if_id_write), .control_dst(control_dst), .if_id_flush(if_id_flush),
    .busy(busy), .stall_count(stall_count)
  );

  hazard_scoreboard #(.PERF_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_mul(id_mul),
    .branch_taken(branch_taken), .perf_clr(perf_clr), .pc_write(sat_pc_write),
    .if_id_write(sat_if_id_write), .control_dst(sat_control_dst),
    .if_id_flush(sat_if_id_flush), .busy(sat_busy), .stall_count(sat_stall_count)
  );

  task automatic checkOutput(input string name, input string field,
                             input logic [15:0] actual, input logic [15:0] expected);
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected while they are applied.
  task automatic applyStimulus(input string name, input logic rstn, input logic v,
                               input logic [4:0] rs, input logic rsu,
                               input logic [4:0] rt, input logic rtu,
                               input logic [4:0] dst, input logic rw, input logic mr,
                               input logic ml, input logic br, input logic clr,
                               input logic ePc, input logic eCd, input logic eFl,
                               input logic eBusy);
    expect_t e;
    @(posedge clk);
    #1;
    rst_n = rstn; id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt;
    id_rt_used = rtu; id_dst = dst; id_regwrite = rw; id_memread = mr; id_mul = ml;
    branch_taken = br; perf_clr = clr;
    if (!rstn) begin
      tally = '0;
      satTally = '0;
    end
    e.name = name; e.pcWrite = ePc; e.controlDst = eCd; e.flush = eFl; e.busy = eBusy;
    e.stallCount = tally; e.satCount = satTally;
    expQ.push_back(e);
    if (rstn) begin
      if (clr) begin
        tally = '0;
        satTally = '0;
      end else if (!ePc) begin
        if (tally != 16'hFFFF) tally = tally + 16'd1;
        if (satTally != 4'hF) satTally = satTally + 4'd1;
      end
    end
  endtask

  task automatic idle(input string name, input logic eBusy);
    applyStimulus(name, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, eBusy);
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        vectorsApplied++;
        checkOutput(e.name, "pc_write", 16'(pc_write), 16'(e.pcWrite));
        checkOutput(e.name, "if_id_write", 16'(if_id_write), 16'(e.pcWrite));
        checkOutput(e.name, "control_dst", 16'(control_dst), 16'(e.controlDst));
        checkOutput(e.name, "if_id_flush", 16'(if_id_flush), 16'(e.flush));
        checkOutput(e.name, "busy", 16'(busy), 16'(e.busy));
        checkOutput(e.name, "stall_count", stall_count, e.stallCount);
        checkOutput(e.name, "sat_stall_count", 16'(sat_stall_count), 16'(e.satCount));
      end
    end
  end

  initial begin
    // name, rstn, valid, rs, rsu, rt, rtu, dst, rw, mr, mul, br, clr, ePc, eCd, eFl, eBusy
    applyStimulus("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle("idle", 0);
    // Load-use: one bubble.
    applyStimulus("ld5", 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("use5_stall", 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("use5_go", 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    idle("after_ld", 0);
    // Multiply: three bubbles on rt.
    applyStimulus("mul9", 1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("use9_stall", 1, 1, 0, 0, 9, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("use9_go", 1, 1, 0, 0, 9, 1, 10, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Multiply takes precedence over load when both flags are set.
    applyStimulus("mulld12", 1, 1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("use12_stall", 1, 1, 12, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("use12_go", 1, 1, 12, 1, 0, 0, 13, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Register zero is never tracked.
    applyStimulus("ld0", 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("use0", 1, 1, 0, 1, 0, 1, 14, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("mul0", 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    idle("after_r0", 0);
    // WAW: ALU write waits for the multiply to drain.
    applyStimulus("mul7", 1, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("waw7_stall", 1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("waw7_go", 1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    idle("after_waw", 0);
    // Back-to-back multiplies to the same register: no stall, issue reloads counter.
    applyStimulus("mul8a", 1, 1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    applyStimulus("mul8b", 1, 1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 1, 1, 0, 1);
    idle("drain8_3", 1);
    idle("drain8_2", 1);
    idle("drain8_1", 1);
    idle("drain8_0", 0);
    // Branch overrides stall; the flushed load must not issue.
    applyStimulus("ld4", 1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("br_use4", 1, 1, 4, 1, 0, 0, 11, 1, 1, 0, 1, 0, 1, 0, 1, 1);
    idle("after_br", 0);
    // Asynchronous reset discards a pending multiply.
    applyStimulus("mul3", 1, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    idle("mul3_pending", 1);
    applyStimulus("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("use3_after_rst", 1, 1, 3, 1, 0, 0, 15, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Self-dependent multiply chain: 3 stalls per 4 cycles drives the narrow counter to saturation.
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0)
        applyStimulus("chain_issue", 1, 1, 9, 1, 0, 0, 9, 1, 0, 1, 0, 0, 1, 1, 0, 0);
      else
        applyStimulus("chain_stall", 1, 1, 9, 1, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    end
    applyStimulus("clr", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    idle("after_clr", 0);
    // Clear wins over an increment in the same cycle.
    applyStimulus("mul9c", 1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    applyStimulus("clr_stall", 1, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus("stall_after_clr", 1, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("stall_last", 1, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("final", 0);
    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d queued, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
